// File: rtl/maj_net_tt_sweep_if.sv
// Request/result bundle for maj_net_tt_sweep: start/config in, status and truth table out.
interface maj_net_tt_sweep_if #(
    parameter int N_IN    = 7,
    parameter int N_GATES = 6,
    parameter int SELW    = $clog2(1 + N_IN + N_GATES),
    parameter int CFG_W   = N_GATES * (3 * SELW + 3) + 1
);
    logic                 start_i;
    logic [CFG_W-1:0]     cfg_i;
    logic                 busy_o;
    logic                 done_o;
    logic [2**N_IN-1:0]   tt_o;
    logic                 cfg_err_o;

    modport master (
        output start_i, cfg_i,
        input  busy_o, done_o, tt_o, cfg_err_o
    );

    modport slave (
        input  start_i, cfg_i,
        output busy_o, done_o, tt_o, cfg_err_o
    );
endinterface

// File: rtl/maj_net_tt_sweep.sv
// Programmable majority-gate network swept over all input minterms to build its truth table.
// Optional popcount output ones_o is enabled by defining MAJ_NET_TT_POPCOUNT_EN.
module maj_net_tt_sweep #(
    parameter int N_IN    = 7,
    parameter int N_GATES = 6,
    parameter int SELW    = $clog2(1 + N_IN + N_GATES),
    parameter int CFG_W   = N_GATES * (3 * SELW + 3) + 1
) (
    input  logic               clk,
    input  logic               rst,
    maj_net_tt_sweep_if.slave  bus
`ifdef MAJ_NET_TT_POPCOUNT_EN
    ,
    output logic [N_IN:0]      ones_o
`endif
);
    localparam int GW   = 3 * SELW + 3;
    localparam int NOPS = 1 + N_IN + N_GATES;
    localparam int NSEL = 2 ** SELW;
    localparam int TT_W = 2 ** N_IN;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t             r_state;
    logic [N_IN:0]      r_cnt;
    logic [CFG_W-1:0]   r_cfg;
    logic [TT_W-1:0]    r_tt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
`ifdef MAJ_NET_TT_POPCOUNT_EN
    logic [N_IN:0]      r_ones;
`endif

    logic               w_f;
    logic               w_cfg_err;

    // Gates resolved in order; ops holds not-yet-evaluated gates (j >= k) at 0,
    // so forward/self references and out-of-range padding read as 0 for free.
    always_comb begin : eval
        logic [N_GATES-1:0] v;
        logic [NSEL-1:0]    ops;
        logic [SELW-1:0]    s;
        logic [2:0]         op;
        v   = '0;
        ops = '0;
        s   = '0;
        op  = '0;
        for (int unsigned k = 0; k < N_GATES; k++) begin
            ops = '0;
            ops[NOPS-1:0] = {v, r_cnt[N_IN-1:0], 1'b0};
            for (int unsigned i = 0; i < 3; i++) begin
                s     = r_cfg[k*GW + i*SELW +: SELW];
                op[i] = ops[s] ^ r_cfg[k*GW + 3*SELW + i];
            end
            v[k] = (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
        end
        w_f = v[N_GATES-1] ^ r_cfg[CFG_W-1];
    end

    // Gate k may only reference const, inputs, or w0..w{k-1}: index <= N_IN + k.
    always_comb begin : chk
        w_cfg_err = 1'b0;
        for (int unsigned k = 0; k < N_GATES; k++) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (int'(bus.cfg_i[k*GW + i*SELW +: SELW]) > N_IN + int'(k))
                    w_cfg_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cfg   <= '0;
            r_tt    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MAJ_NET_TT_POPCOUNT_EN
            r_ones  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_i) begin
                        r_cfg   <= bus.cfg_i;
                        r_err   <= w_cfg_err;
                        r_cnt   <= '0;
                        r_tt    <= '0;
                        r_busy  <= 1'b1;
`ifdef MAJ_NET_TT_POPCOUNT_EN
                        r_ones  <= '0;
`endif
                        r_state <= SWEEP;
                    end
                end
                SWEEP: begin
                    r_tt[r_cnt[N_IN-1:0]] <= w_f;
                    r_cnt <= r_cnt + 1'b1;
`ifdef MAJ_NET_TT_POPCOUNT_EN
                    r_ones <= r_ones + {{N_IN{1'b0}}, w_f};
`endif
                    if (r_cnt[N_IN-1:0] == '1) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.tt_o      = r_tt;
    assign bus.cfg_err_o = r_err;
`ifdef MAJ_NET_TT_POPCOUNT_EN
    assign ones_o        = r_ones;
`endif
endmodule
